out_frame_packer: RTL and testbench

Frame packer for the M/2 polyphase channelizer synthesis bank, directly downstream of the synthesis output buffer. It consumes the buffer's sample stream, phase index and final-count flag, and aligns the output to whole frames of M/2 samples. It checks phase continuity, adds AXI-Stream `tlast` and a per-frame sequence number, and decouples downstream backpressure with a registered 2-entry skid buffer.

---
 rtl/out_frame_packer_if.sv | 46 ++++
 rtl/out_frame_packer.sv | 202 ++++++++++++++++++++
 tb/tb_out_frame_packer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/out_frame_packer_if.sv
// ----------------------------------------------------------------------------
// out_frame_packer_if
//   Stream bundle around the frame packer. It carries the upstream sample
//   stream from the synthesis output buffer (s_axis_*) and the framed
//   AXI-Stream output (m_axis_*).
//
//   Handshake: a beat moves on a rising edge where tvalid & tready are both
//   high. A source holding tvalid=1 keeps its payload stable until it sees
//   tready. tready may change in any cycle and never depends on tvalid
//   combinationally.
//
//   Modports:
//     master - environment side: feeds s_axis_*, consumes m_axis_*
//     slave  - packer side: consumes s_axis_*, drives m_axis_*
// ----------------------------------------------------------------------------
interface out_frame_packer_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int FFT_SIZE_WIDTH  = 12,
    parameter int FRAME_CNT_WIDTH = 16
);
    logic                       s_axis_tvalid;
    logic                       s_axis_tready;
    logic [DATA_WIDTH-1:0]      s_axis_tdata;
    logic [FFT_SIZE_WIDTH-2:0]  s_axis_phase;
    logic                       s_axis_final_cnt;

    logic                       m_axis_tvalid;
    logic                       m_axis_tready;
    logic [DATA_WIDTH-1:0]      m_axis_tdata;
    logic                       m_axis_tlast;
    logic [FRAME_CNT_WIDTH-1:0] m_axis_tuser;

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_phase, s_axis_final_cnt,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_phase, s_axis_final_cnt,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/out_frame_packer.sv
// ----------------------------------------------------------------------------
// out_frame_packer
//   Aligns the synthesis-bank sample stream to whole frames of M/2 samples,
//   checks phase continuity, adds tlast and a per-frame sequence number in
//   tuser, and isolates downstream backpressure with a 2-entry skid buffer.
//
//   Ports:
//     clk           - rising-edge clock
//     sync_reset_n  - synchronous active-low reset
//     fft_size      - channel count M (power of 2), sampled only while syncing
//     bus           - stream bundle (slave modport): s_axis_* in, m_axis_* out
//     seq_err       - sticky phase / final-count mismatch flag
//     dbg_state_o   - current FSM state (0 = S_SYNC, 1 = S_PASS)
// ----------------------------------------------------------------------------
module out_frame_packer #(
    parameter int DATA_WIDTH      = 32,
    parameter int FFT_SIZE_WIDTH  = 12,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      sync_reset_n,
    input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
    out_frame_packer_if.slave         bus,
    output logic                      seq_err,
    output logic                      dbg_state_o
);
    localparam int PW = FFT_SIZE_WIDTH - 1;

    typedef enum logic {
        S_SYNC = 1'b0,
        S_PASS = 1'b1
    } state_t;

    state_t                     state_q;
    logic [PW-1:0]              half_m_q;
    logic [PW-1:0]              exp_phase_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;
    logic                       seq_err_q;
    logic                       s_tready_q;

    // Output buffer: main register drives m_axis_*, skid catches one push
    // that arrives while main is stalled.
    logic                       main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0]      main_data_q,  main_data_d;
    logic                       main_last_q,  main_last_d;
    logic [FRAME_CNT_WIDTH-1:0] main_user_q,  main_user_d;
    logic                       skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0]      skid_data_q,  skid_data_d;
    logic                       skid_last_q,  skid_last_d;
    logic [FRAME_CNT_WIDTH-1:0] skid_user_q,  skid_user_d;

    logic          accept;
    logic [PW-1:0] half_m_cur;
    logic [PW-1:0] last_phase;
    logic [PW-1:0] ref_phase;
    logic          phase_ok;
    logic          at_last;
    logic          push;
    logic          pop;

    // ------------------------------------------------------------------
    // Beat classification
    // ------------------------------------------------------------------
    always_comb begin
        accept     = bus.s_axis_tvalid & s_tready_q;
        // While syncing the frame length follows fft_size live, so a phase-0
        // beat accepted in the same cycle uses the value being registered.
        half_m_cur = (state_q == S_SYNC) ? PW'(fft_size >> 1) : half_m_q;
        last_phase = half_m_cur - PW'(1);
        ref_phase  = (state_q == S_SYNC) ? '0 : exp_phase_q;
        phase_ok   = (bus.s_axis_phase == ref_phase);
        // With half_m == 1, phase 0 is both first and last beat of a frame.
        at_last    = (ref_phase == last_phase);
        // final_cnt is only checked once locked; while syncing any phase-0
        // beat starts a frame.
        push       = accept & phase_ok &
                     ((state_q == S_SYNC) | (bus.s_axis_final_cnt == at_last));
        pop        = main_valid_q & bus.m_axis_tready;
    end

    // ------------------------------------------------------------------
    // Skid buffer next state (strict FIFO: skid always drains into main
    // before a new push can reach main).
    // ------------------------------------------------------------------
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_user_d  = main_user_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_user_d  = skid_user_q;

        if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                main_user_d  = skid_user_q;
                skid_valid_d = push;
                if (push) begin
                    skid_data_d = bus.s_axis_tdata;
                    skid_last_d = at_last;
                    skid_user_d = frame_cnt_q;
                end
            end else begin
                main_valid_d = push;
                if (push) begin
                    main_data_d = bus.s_axis_tdata;
                    main_last_d = at_last;
                    main_user_d = frame_cnt_q;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.s_axis_tdata;
            skid_last_d  = at_last;
            skid_user_d  = frame_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // FSM, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state_q      <= S_SYNC;
            half_m_q     <= '0;
            exp_phase_q  <= '0;
            frame_cnt_q  <= '0;
            seq_err_q    <= 1'b0;
            s_tready_q   <= 1'b0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_user_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_user_q  <= '0;
        end else begin
            if (state_q == S_SYNC) begin
                half_m_q <= half_m_cur;
            end

            if (accept) begin
                case (state_q)
                    S_SYNC: begin
                        // Non-zero phases are drained silently.
                        if (push) begin
                            state_q <= S_PASS;
                            if (at_last) begin
                                exp_phase_q <= '0;
                                frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
                            end else begin
                                exp_phase_q <= PW'(1);
                            end
                        end
                    end
                    S_PASS: begin
                        if (push) begin
                            if (at_last) begin
                                exp_phase_q <= '0;
                                frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
                            end else begin
                                exp_phase_q <= exp_phase_q + PW'(1);
                            end
                        end else begin
                            // Broken sequence: drop the beat and resync; the
                            // partial frame is left without tlast.
                            seq_err_q <= 1'b1;
                            state_q   <= S_SYNC;
                        end
                    end
                    default: state_q <= S_SYNC;
                endcase
            end

            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_user_q  <= main_user_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_user_q  <= skid_user_d;
            // Ready drops the same edge the skid fills, so at most the one
            // beat already in flight lands in skid.
            s_tready_q   <= ~skid_valid_d;
        end
    end

    assign bus.s_axis_tready = s_tready_q;
    assign bus.m_axis_tvalid = main_valid_q;
    assign bus.m_axis_tdata  = main_data_q;
    assign bus.m_axis_tlast  = main_last_q;
    assign bus.m_axis_tuser  = main_user_q;
    assign seq_err           = seq_err_q;
    assign dbg_state_o       = (state_q == S_PASS);

endmodule

// File: tb/tb_out_frame_packer.sv
module tb_out_frame_packer;
  localparam int DW = 32;
  localparam int FW = 12;
  localparam int CW = 2;
  localparam int PW = FW - 1;
  localparam int EW = DW + 1 + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic sync_reset_n = 1'b0;
  logic [FW-1:0] fft_size;
  logic seq_err;
  logic dbg_state;

  always #5 clk = ~clk;

  out_frame_packer_if #(.DATA_WIDTH(DW), .FFT_SIZE_WIDTH(FW), .FRAME_CNT_WIDTH(CW)) bus ();

  out_frame_packer #(.DATA_WIDTH(DW), .FFT_SIZE_WIDTH(FW), .FRAME_CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .fft_size     (fft_size),
    .bus          (bus),
    .seq_err      (seq_err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int cyc = 0;
  logic drv_keep = 1'b0;
  logic bp_en = 1'b0;
  int occ = 0;
  logic prev_stall = 1'b0;
  logic [EW-1:0] prev_beat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- output monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    logic [EW-1:0] beat;
    logic [EW-1:0] e;
    beat = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
    if (!sync_reset_n) begin
      prev_stall = 1'b0;
      occ = 0;
    end else begin
      if (prev_stall) begin
        check("axi_hold_valid", 64'(bus.m_axis_tvalid), 64'd1);
        check("axi_hold_beat", 64'(beat), 64'(prev_beat));
      end
      if (bp_en) begin
        check("occ_s_tready", 64'(bus.s_axis_tready), 64'(occ < 2));
        check("occ_m_tvalid", 64'(bus.m_axis_tvalid), 64'(occ != 0));
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(bus.m_axis_tvalid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_tdata", 64'(bus.m_axis_tdata), 64'(e[EW-1 -: DW]));
          check("out_tlast", 64'(bus.m_axis_tlast), 64'(e[CW]));
          check("out_tuser", 64'(bus.m_axis_tuser), 64'(e[CW-1:0]));
        end
      end
      occ = occ + ((bus.s_axis_tvalid && bus.s_axis_tready && drv_keep) ? 1 : 0)
                - ((bus.m_axis_tvalid && bus.m_axis_tready) ? 1 : 0);
      prev_stall = bus.m_axis_tvalid & ~bus.m_axis_tready;
      prev_beat = beat;
    end
  end

  // ---------------- backpressure pattern 1-0-0-1 ----------------
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.m_axis_tready = ((k % 4) == 0) || ((k % 4) == 3);
        k++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    sync_reset_n = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    drv_keep = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(bus.m_axis_tdata), 64'd0);
    check("rst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
    check("rst_m_tuser", 64'(bus.m_axis_tuser), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    sync_reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_s_tready", 64'(bus.s_axis_tready), 64'd1);
  endtask

  // Drive one beat; keep/last/user describe the hand-computed output (if any).
  task automatic send(input int ph, input bit fc, input logic [DW-1:0] d,
                      input bit keep, input bit last, input int user);
    int budget;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_phase = PW'(ph);
    bus.s_axis_final_cnt = fc;
    bus.s_axis_tdata = d;
    drv_keep = keep;
    if (keep) exp_q.push_back({d, last, CW'(user)});
    budget = 0;
    forever begin
      @(negedge clk);
      if (bus.s_axis_tready) break;
      budget++;
      if (budget > 100) begin
        check("s_tready_timeout", 64'(bus.s_axis_tready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.s_axis_tvalid = 1'b0;
    drv_keep = 1'b0;
  endtask

  task automatic send_frame(input int half, input int user, input logic [DW-1:0] base);
    for (int p = 0; p < half; p++)
      send(p, p == half - 1, base + DW'(p), 1'b1, p == half - 1, user);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata = '0;
    bus.s_axis_phase = '0;
    bus.s_axis_final_cnt = 1'b0;
    bus.m_axis_tready = 1'b1;
    fft_size = 12'd64;

    do_reset();

    // Normal frames: M=64, 3 frames, tuser 0,1,2, latency 1, 1 beat/clk.
    fft_size = 12'd64;
    c0 = cyc;
    send(0, 1'b0, 32'h1000_0000, 1'b1, 1'b0, 0);
    check("latency_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    check("latency_tdata", 64'(bus.m_axis_tdata), 64'h1000_0000);
    for (int p = 1; p < 32; p++)
      send(p, p == 31, 32'h1000_0000 + DW'(p), 1'b1, p == 31, 0);
    send_frame(32, 1, 32'h1100_0000);
    send_frame(32, 2, 32'h1200_0000);
    check("throughput_cycles", 64'(cyc - c0), 64'd96);
    check("normal_state", 64'(dbg_state), 64'd1);
    wait_drain();
    check("normal_seq_err", 64'(seq_err), 64'd0);

    // Mid-frame start: M=16, phases 5..7 discarded, then frame with tuser 0.
    do_reset();
    fft_size = 12'd16;
    send(5, 1'b0, 32'h2000_0005, 1'b0, 1'b0, 0);
    send(6, 1'b0, 32'h2000_0006, 1'b0, 1'b0, 0);
    send(7, 1'b1, 32'h2000_0007, 1'b0, 1'b0, 0);
    check("midstart_state", 64'(dbg_state), 64'd0);
    check("midstart_no_out", 64'(bus.m_axis_tvalid), 64'd0);
    send_frame(8, 0, 32'h2100_0000);
    wait_drain();
    check("midstart_seq_err", 64'(seq_err), 64'd0);

    // Backpressure: M=32, 2 frames, m_axis_tready 1-0-0-1.
    do_reset();
    fft_size = 12'd32;
    bp_en = 1'b1;
    send_frame(16, 0, 32'h3000_0000);
    send_frame(16, 1, 32'h3100_0000);
    bp_en = 1'b0;
    bus.m_axis_tready = 1'b1;
    wait_drain();
    check("bp_seq_err", 64'(seq_err), 64'd0);

    // Phase skip: M=16, 0,1,2,4 -> beat 4 dropped, sticky seq_err.
    do_reset();
    fft_size = 12'd16;
    send(0, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 0);
    send(1, 1'b0, 32'h4000_0001, 1'b1, 1'b0, 0);
    send(2, 1'b0, 32'h4000_0002, 1'b1, 1'b0, 0);
    send(4, 1'b0, 32'h4000_0004, 1'b0, 1'b0, 0);
    check("skip_seq_err", 64'(seq_err), 64'd1);
    check("skip_state", 64'(dbg_state), 64'd0);
    send_frame(8, 0, 32'h4100_0000);
    wait_drain();
    check("skip_seq_err_sticky", 64'(seq_err), 64'd1);

    // Missing final_cnt: M=16, phase 7 with final_cnt=0 is dropped.
    do_reset();
    fft_size = 12'd16;
    for (int p = 0; p < 7; p++)
      send(p, 1'b0, 32'h5000_0000 + DW'(p), 1'b1, 1'b0, 0);
    send(7, 1'b0, 32'h5000_0007, 1'b0, 1'b0, 0);
    check("nofinal_seq_err", 64'(seq_err), 64'd1);
    check("nofinal_state", 64'(dbg_state), 64'd0);
    send_frame(8, 0, 32'h5100_0000);
    wait_drain();

    // Reset with 2 beats buffered, then tuser wrap over 5 frames (2-bit count).
    do_reset();
    fft_size = 12'd16;
    bus.m_axis_tready = 1'b0;
    send(0, 1'b0, 32'h6000_0000, 1'b1, 1'b0, 0);
    send(1, 1'b0, 32'h6000_0001, 1'b1, 1'b0, 0);
    check("full_s_tready", 64'(bus.s_axis_tready), 64'd0);
    check("full_m_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
    do_reset();
    bus.m_axis_tready = 1'b1;
    send_frame(8, 0, 32'h6100_0000);
    send_frame(8, 1, 32'h6200_0000);
    send_frame(8, 2, 32'h6300_0000);
    send_frame(8, 3, 32'h6400_0000);
    send_frame(8, 0, 32'h6500_0000);
    wait_drain();
    check("wrap_seq_err", 64'(seq_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
